// File: rtl/connect4_turn_ctrl_pkg.sv
// Shared types and geometry for the Connect-4 Pop turn controller.
// The board is 7 columns by 6 rows; cell index = col*6 + row, row 0 at the bottom.
package connect4_turn_ctrl_pkg;

  localparam int C4_COLS    = 7;
  localparam int C4_ROWS    = 6;
  localparam int C4_WINDOWS = 69;

  localparam logic       PLAYER_RED = 1'b1;
  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_YEL    = 2'b01;
  localparam logic [1:0] WIN_RED    = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_SCAN,
    ST_RESOLVE,
    ST_OVER
  } state_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
    return 6'(col * 6) + 6'(row);
  endfunction

endpackage

// File: rtl/c4_window_rom.sv
// Maps a window number (0..68) to the four cell indices of that four-in-a-row window.
// Order: 24 horizontal, 21 vertical, 12 rising diagonals, 12 falling diagonals.
module c4_window_rom
  import connect4_turn_ctrl_pkg::*;
(
  input  logic [6:0]      win_idx,
  output logic [3:0][5:0] cells
);

  logic [6:0] rel;
  logic [2:0] col0;
  logic [2:0] row0;
  logic [5:0] step;
  logic [5:0] base;

  always_comb begin
    rel  = '0;
    col0 = '0;
    row0 = '0;
    step = '0;
    if (win_idx < 7'd24) begin
      col0 = {1'b0, win_idx[1:0]};
      row0 = win_idx[4:2];
      step = 6'd6;
    end else if (win_idx < 7'd45) begin
      rel  = win_idx - 7'd24;
      col0 = 3'(rel / 7'd3);
      row0 = 3'(rel % 7'd3);
      step = 6'd1;
    end else if (win_idx < 7'd57) begin
      rel  = win_idx - 7'd45;
      col0 = 3'(rel / 7'd3);
      row0 = 3'(rel % 7'd3);
      step = 6'd7;
    end else begin
      // falling diagonal: next column, one row lower -> +6 - 1
      rel  = win_idx - 7'd57;
      col0 = 3'(rel / 7'd3);
      row0 = 3'(rel % 7'd3 + 7'd3);
      step = 6'd5;
    end
    base  = cell_idx(col0, row0);
    cells = '0;
    for (int k = 0; k < 4; k++) begin
      cells[k] = base + 6'(k) * step;
    end
  end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 Pop game sequencer: validates keypad moves, issues board commands,
// scans all 69 windows after each move and resolves win/draw, turn and scores.
module connect4_turn_ctrl
  import connect4_turn_ctrl_pkg::*;
#(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6,
  parameter int SCORE_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_col,
  input  logic                     key_pop,
  input  logic                     reset_game,
  input  logic                     reset_score,
  input  logic [3*NUM_COLS-1:0]    col_height,
  input  logic [NUM_COLS*NUM_ROWS-1:0] board_occ,
  input  logic [NUM_COLS*NUM_ROWS-1:0] board_own,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_op,
  output logic [2:0]               cmd_col,
  output logic                     cmd_player,
  output logic                     board_clear,
  output logic                     player,
  output logic                     move_err,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic [SCORE_W-1:0]       score_red,
  output logic [SCORE_W-1:0]       score_yellow
);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic                 player_q, player_d;
  logic [6:0]           cnt_q, cnt_d;
  logic                 red_hit_q, red_hit_d, yel_hit_q, yel_hit_d;
  logic                 over_q, over_d;
  logic [1:0]           winner_q, winner_d;
  logic [SCORE_W-1:0]   sred_q, sred_d, syel_q, syel_d;
  logic                 err_q, err_d;
  logic                 clr_q, clr_d;
  logic                 rg_q;
  logic                 latch_en;
  logic                 op_q, mover_q;
  logic [2:0]           col_q;

  // Padded copies so out-of-range column/cell lookups read zeros.
  logic [63:0]          occ_ext, own_ext;
  logic [23:0]          hts_ext;
  assign occ_ext = 64'(board_occ);
  assign own_ext = 64'(board_own);
  assign hts_ext = 24'(col_height);

  logic [2:0] kc;
  logic [4:0] h_lsb;
  logic [2:0] key_h;
  logic [5:0] bot;
  logic       col_ok, drop_ok, pop_ok;

  assign kc      = key_col[2:0];
  assign h_lsb   = 5'(kc) * 5'd3;
  assign key_h   = hts_ext[h_lsb +: 3];
  assign bot     = cell_idx(kc, 3'd0);
  assign col_ok  = key_col <= 4'(NUM_COLS - 1);
  assign drop_ok = col_ok && (key_h < 3'(NUM_ROWS));
  assign pop_ok  = col_ok && (key_h != 3'd0) && occ_ext[bot] && (own_ext[bot] == player_q);

  logic [3:0][5:0] cells;
  logic [3:0]      w_occ, w_own;
  logic            hit_red, hit_yel;

  c4_window_rom u_rom (
    .win_idx (cnt_q),
    .cells   (cells)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_occ[k] = occ_ext[cells[k]];
      w_own[k] = own_ext[cells[k]];
    end
  end

  assign hit_red = (&w_occ) && (&w_own);
  assign hit_yel = (&w_occ) && !(|w_own);

  logic all_full;
  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (hts_ext[3*c +: 3] != 3'(NUM_ROWS)) all_full = 1'b0;
    end
  end

  logic mover_hit, opp_hit, win_col;
  assign mover_hit = mover_q ? red_hit_q : yel_hit_q;
  assign opp_hit   = mover_q ? yel_hit_q : red_hit_q;
  assign win_col   = mover_hit ? mover_q : ~mover_q;

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    cnt_d     = cnt_q;
    red_hit_d = red_hit_q;
    yel_hit_d = yel_hit_q;
    over_d    = over_q;
    winner_d  = winner_q;
    sred_d    = sred_q;
    syel_d    = syel_q;
    err_d     = 1'b0;
    latch_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          if (key_pop ? pop_ok : drop_ok) begin
            latch_en = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE:  if (cmd_ready) state_d = ST_SETTLE;
      ST_SETTLE: begin
        cnt_d     = '0;
        red_hit_d = 1'b0;
        yel_hit_d = 1'b0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        red_hit_d = red_hit_q | hit_red;
        yel_hit_d = yel_hit_q | hit_yel;
        if (cnt_q == 7'(C4_WINDOWS - 1)) state_d = ST_RESOLVE;
        else                             cnt_d   = cnt_q + 7'd1;
      end
      ST_RESOLVE: begin
        if (mover_hit || opp_hit) begin
          winner_d = win_col ? WIN_RED : WIN_YEL;
          if (win_col) sred_d = sat_inc(sred_q);
          else         syel_d = sat_inc(syel_q);
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else if (all_full) begin
          winner_d = WIN_DRAW;
          over_d   = 1'b1;
          state_d  = ST_OVER;
        end else begin
          player_d = ~player_q;
          state_d  = ST_IDLE;
        end
      end
      ST_OVER: if (key_valid) err_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (reset_score) begin
      sred_d = '0;
      syel_d = '0;
    end
    // Game restart wins over everything except the scores.
    if (reset_game) begin
      state_d   = ST_IDLE;
      player_d  = PLAYER_RED;
      winner_d  = WIN_NONE;
      over_d    = 1'b0;
      red_hit_d = 1'b0;
      yel_hit_d = 1'b0;
      err_d     = 1'b0;
      latch_en  = 1'b0;
    end
    clr_d = reset_game && !rg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      player_q  <= PLAYER_RED;
      cnt_q     <= '0;
      red_hit_q <= 1'b0;
      yel_hit_q <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= WIN_NONE;
      sred_q    <= '0;
      syel_q    <= '0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      rg_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      cnt_q     <= cnt_d;
      red_hit_q <= red_hit_d;
      yel_hit_q <= yel_hit_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      sred_q    <= sred_d;
      syel_q    <= syel_d;
      err_q     <= err_d;
      clr_q     <= clr_d;
      rg_q      <= reset_game;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_q    <= key_pop;
      col_q   <= kc;
      mover_q <= player_q;
    end
  end

  assign cmd_valid    = (state_q == ST_ISSUE);
  assign cmd_op       = op_q;
  assign cmd_col      = col_q;
  assign cmd_player   = mover_q;
  assign board_clear  = clr_q;
  assign player       = player_q;
  assign move_err     = err_q;
  assign game_over    = over_q;
  assign winner       = winner_q;
  assign score_red    = sred_q;
  assign score_yellow = syel_q;

endmodule
